gt_run_detector: RTL and testbench
==================================

// Module: gt_run_detector
// PURPOSE
//   Moore-machine consumer of the mag_compare A_gt_B flag. It samples the flag
//   on qualified cycles and detects a run of RUN_LEN consecutive "A > B" samples.
//   It flags the detection level and a one-cycle entry pulse, and keeps a
//   saturating count of detected runs. Sits directly downstream of mag_compare.
// PARAMETERS
//   RUN_LEN    3   consecutive gt samples required to detect; legal range 2..15
//   CNT_WIDTH  4   width of hit_count
// PORTS
//   clock       input   1          rising-edge clock
//   reset       input   1          asynchronous, active-high reset
//   clear       input   1          synchronous clear of FSM, run counter and hit_count
//   sample_en   input   1          qualifies a_gt_b; sampled only when 1
//   a_gt_b      input   1          A_gt_B from mag_compare
//   detect      output  1          1 while FSM in FIRST_HIT or HOLD_HIT
//   hit_pulse   output  1          1 for exactly one cycle, in FIRST_HIT
//   hit_count   output  CNT_WIDTH  number of FIRST_HIT entries, saturating
//   run_len     output  4          current run of consecutive gt samples, saturates at RUN_LEN
// BEHAVIOUR
//   Reset and clock
//   - One clock. Reset is asynchronous and active-high.
//   - Reset forces state=IDLE, run_len=0, hit_count=0, detect=0, hit_pulse=0.
//   - Reset mid-run discards the run immediately, without waiting for a clock edge.
//   Outputs and priority
//   - All outputs are registered, Moore-decoded from state and counters only.
//   - No combinational path from any input to any output.
//   - Latency: a sample taken at edge k is reflected in the outputs after edge k.
//   - Priority at each edge: clear > sample_en. Clear behaves like reset, but synchronously.
//   - sample_en=0: state, run_len and hit_count hold. Exception: FIRST_HIT -> HOLD_HIT (below).
//   States (S = sample_en & a_gt_b, N = sample_en & ~a_gt_b)
//   - IDLE       run_len=0, detect=0, hit_pulse=0
//                S -> COUNT with run_len=1.
//   - COUNT      0<run_len<RUN_LEN, detect=0
//                S & run_len==RUN_LEN-1 -> FIRST_HIT with run_len=RUN_LEN.
//                S otherwise -> COUNT with run_len+1.
//                N -> IDLE with run_len=0.
//   - FIRST_HIT  detect=1, hit_pulse=1, run_len=RUN_LEN
//                N -> IDLE. Any other input -> HOLD_HIT.
//                Entering FIRST_HIT increments hit_count unless it is at all-ones (saturate, no wrap).
//   - HOLD_HIT   detect=1, hit_pulse=0, run_len=RUN_LEN
//                N -> IDLE. Otherwise stay.
//   Boundary conditions
//   - Further gt samples in HOLD_HIT do not re-trigger a hit or count again.
//   - Only a break in the run (N) followed by a new full run re-arms detection.
//   - Illegal state encodings recover to IDLE on the next edge.
//   - clear and sample_en in the same cycle: the clear wins and the sample is dropped.
// TESTING  (RUN_LEN=3, CNT_WIDTH=4; drive A/B through a mag_compare instance)
//   1. Release reset, no samples -> detect=0, hit_pulse=0, hit_count=0, run_len=0.
//   2. Three sample_en cycles with A=2'b11, B=2'b01 ->
//      run_len goes 1,2,3; hit_pulse high only after the 3rd edge; detect stays 1; hit_count=1.
//   3. Pattern gt,gt,eq(A=B=2'b10),gt,gt,gt ->
//      run_len goes 1,2,0,1,2,3; exactly one hit_pulse; hit_count=1.
//   4. Hold sample_en=0 for 5 cycles mid-run at run_len=2 ->
//      run_len stays 2; the next gt sample gives FIRST_HIT.
//   5. Twenty full runs, each separated by an lt sample ->
//      hit_count saturates at 4'hF with no wrap; twenty hit_pulse cycles.
//   6. Assert reset asynchronously mid-COUNT, then clear together with a gt sample in HOLD_HIT ->
//      all outputs go to 0 immediately on reset; after the clear edge state=IDLE, run_len=0, hit_count=0.

Source files
------------

// File: rtl/gt_run_detector.sv
// gt_run_detector: Moore detector for runs of consecutive A>B samples.
// Counts detected runs in a saturating hit counter.
module gt_run_detector #(
  parameter int RUN_LEN   = 3,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 sample_en,
  input  logic                 a_gt_b,
  output logic                 detect,
  output logic                 hit_pulse,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [3:0]           run_len
);

  localparam logic [2:0] IDLE      = 3'b000;
  localparam logic [2:0] COUNT     = 3'b001;
  localparam logic [2:0] FIRST_HIT = 3'b010;
  localparam logic [2:0] HOLD_HIT  = 3'b100;

  localparam logic [3:0] RUN_MAX  = 4'(RUN_LEN);
  localparam logic [3:0] RUN_LAST = 4'(RUN_LEN - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = '1;

  logic [2:0]           state_q;
  logic [2:0]           state_d;
  logic [3:0]           run_q;
  logic [3:0]           run_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 detect_q;
  logic                 detect_d;
  logic                 pulse_q;
  logic                 pulse_d;

  logic s_hit;
  logic s_miss;

  assign s_hit  = sample_en & a_gt_b;
  assign s_miss = sample_en & ~a_gt_b;

  // State, counter and output flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      run_q    <= 4'd0;
      cnt_q    <= '0;
      detect_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      detect_q <= detect_d;
      pulse_q  <= pulse_d;
    end
  end

  // Next state and counter updates; clear overrides any sample
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      run_d   = 4'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          run_d = 4'd0;
          if (s_hit) begin
            state_d = COUNT;
            run_d   = 4'd1;
          end
        end
        COUNT: begin
          if (s_hit) begin
            if (run_q == RUN_LAST) begin
              state_d = FIRST_HIT;
              run_d   = RUN_MAX;
              if (cnt_q != CNT_SAT)
                cnt_d = cnt_q + 1'b1;
            end else begin
              run_d = run_q + 4'd1;
            end
          end else if (s_miss) begin
            state_d = IDLE;
            run_d   = 4'd0;
          end
        end
        FIRST_HIT: begin
          run_d = RUN_MAX;
          if (s_miss) begin
            state_d = IDLE;
            run_d   = 4'd0;
          end else begin
            state_d = HOLD_HIT;
          end
        end
        HOLD_HIT: begin
          run_d = RUN_MAX;
          if (s_miss) begin
            state_d = IDLE;
            run_d   = 4'd0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = 4'd0;
        end
      endcase
    end
  end

  // Moore decode of the upcoming state into registered flags
  always_comb begin
    detect_d = 1'b0;
    pulse_d  = 1'b0;
    case (state_d)
      FIRST_HIT: begin
        detect_d = 1'b1;
        pulse_d  = 1'b1;
      end
      HOLD_HIT: detect_d = 1'b1;
      default: begin
        detect_d = 1'b0;
        pulse_d  = 1'b0;
      end
    endcase
  end

  assign detect    = detect_q;
  assign hit_pulse = pulse_q;
  assign hit_count = cnt_q;
  assign run_len   = run_q;

endmodule

// File: tb/tb_gt_run_detector.sv
// tb_gt_run_detector: scoreboard bench for gt_run_detector.
// A/B are compared in the bench to form a_gt_b.
module tb_gt_run_detector;

  localparam int RUN_LEN = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       sample_en = 1'b0;
  logic [1:0] a_val = 2'b00;
  logic [1:0] b_val = 2'b00;
  logic       a_gt_b;
  logic       detect;
  logic       hit_pulse;
  logic [3:0] hit_count;
  logic [3:0] run_len;

  assign a_gt_b = (a_val > b_val);

  always #5 clock = ~clock;

  gt_run_detector #(.RUN_LEN(RUN_LEN), .CNT_WIDTH(4)) dut (
    .clock(clock), .reset(reset), .clear(clear),
    .sample_en(sample_en), .a_gt_b(a_gt_b),
    .detect(detect), .hit_pulse(hit_pulse),
    .hit_count(hit_count), .run_len(run_len)
  );

  typedef struct packed {
    logic       det;
    logic       pul;
    logic [3:0] cnt;
    logic [3:0] run;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_run = 0;
  int   m_cnt = 0;
  bit   m_pulse = 0;

  function automatic void model(input bit se, input bit gt, input bit clr);
    if (clr) begin
      m_run = 0; m_cnt = 0; m_pulse = 0;
    end else if (se && gt) begin
      m_pulse = 0;
      if (m_run < RUN_LEN) begin
        m_run++;
        if (m_run == RUN_LEN) begin
          m_pulse = 1;
          if (m_cnt < 15) m_cnt++;
        end
      end
    end else if (se) begin
      m_run = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
    end
  endfunction

  task automatic step(input logic se, input logic [1:0] a,
                      input logic [1:0] b, input logic clr,
                      input string tag);
    exp_t e;
    exp_t o;
    @(negedge clock);
    sample_en = se; a_val = a; b_val = b; clear = clr;
    model(se, a > b, clr);
    e.det = (m_run == RUN_LEN);
    e.pul = m_pulse;
    e.cnt = 4'(m_cnt);
    e.run = 4'(m_run);
    q.push_back(e);
    @(posedge clock);
    #1;
    e = q.pop_front();
    o = '{detect, hit_pulse, hit_count, run_len};
    tests++;
    if (o !== e) begin
      fails++;
      $display("FAIL %s: got det=%b pul=%b cnt=%0d run=%0d want det=%b pul=%b cnt=%0d run=%0d",
               tag, o.det, o.pul, o.cnt, o.run, e.det, e.pul, e.cnt, e.run);
    end
    sample_en = 1'b0; clear = 1'b0;
  endtask

  task automatic gt(input string t);  step(1, 2'b11, 2'b01, 0, t); endtask
  task automatic eq(input string t);  step(1, 2'b10, 2'b10, 0, t); endtask
  task automatic lt(input string t);  step(1, 2'b00, 2'b11, 0, t); endtask
  task automatic idle(input string t); step(0, 2'($urandom), 2'($urandom), 0, t); endtask
  task automatic clr(input string t); step(0, 2'b00, 2'b00, 1, t); endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    tests++;
    if ({detect, hit_pulse, hit_count, run_len} !== 10'd0) begin
      fails++;
      $display("FAIL reset_hold: got %b want 0", {detect, hit_pulse, hit_count, run_len});
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (2) idle("reset_idle");
  endtask

  task automatic test_basic_run();
    clr("basic_clr");
    gt("basic_gt1");
    gt("basic_gt2");
    gt("basic_gt3");
    gt("basic_hold");
    tests++;
    if (hit_count !== 4'd1 || detect !== 1'b1) begin
      fails++;
      $display("FAIL basic_end: got cnt=%0d det=%b want cnt=1 det=1", hit_count, detect);
    end
  endtask

  task automatic test_break();
    int pulses = 0;
    clr("break_clr");
    gt("break_gt1"); pulses += hit_pulse;
    gt("break_gt2"); pulses += hit_pulse;
    eq("break_eq");  pulses += hit_pulse;
    gt("break_gt3"); pulses += hit_pulse;
    gt("break_gt4"); pulses += hit_pulse;
    gt("break_gt5"); pulses += hit_pulse;
    gt("break_gt6"); pulses += hit_pulse;
    tests++;
    if (pulses != 1 || hit_count !== 4'd1) begin
      fails++;
      $display("FAIL break_pulses: got pulses=%0d cnt=%0d want 1 1", pulses, hit_count);
    end
  endtask

  task automatic test_stall();
    clr("stall_clr");
    gt("stall_gt1");
    gt("stall_gt2");
    repeat (5) idle("stall_idle");
    gt("stall_gt3");
    tests++;
    if (hit_pulse !== 1'b1 || run_len !== 4'd3) begin
      fails++;
      $display("FAIL stall_hit: got pul=%b run=%0d want 1 3", hit_pulse, run_len);
    end
    idle("stall_after");
  endtask

  task automatic test_saturate();
    int pulses = 0;
    clr("sat_clr");
    for (int i = 0; i < 20; i++) begin
      gt("sat_gt"); pulses += hit_pulse;
      gt("sat_gt"); pulses += hit_pulse;
      gt("sat_gt"); pulses += hit_pulse;
      lt("sat_lt"); pulses += hit_pulse;
    end
    tests++;
    if (pulses != 20 || hit_count !== 4'hF) begin
      fails++;
      $display("FAIL sat_end: got pulses=%0d cnt=%0d want 20 15", pulses, hit_count);
    end
  endtask

  task automatic test_async_and_clear();
    gt("async_gt1");
    gt("async_gt2");
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if ({detect, hit_pulse, hit_count, run_len} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset: got %b want 0", {detect, hit_pulse, hit_count, run_len});
    end
    m_run = 0; m_cnt = 0; m_pulse = 0;
    @(negedge clock);
    reset = 1'b0;
    gt("post_gt1");
    gt("post_gt2");
    gt("post_gt3");
    gt("post_hold");
    step(1, 2'b11, 2'b00, 1, "clear_with_gt");
    tests++;
    if (run_len !== 4'd0 || hit_count !== 4'd0 || detect !== 1'b0) begin
      fails++;
      $display("FAIL clear_end: got run=%0d cnt=%0d det=%b want 0 0 0",
               run_len, hit_count, detect);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_break();
    test_stall();
    test_saturate();
    test_async_and_clear();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
